// File: rtl/mem_burst_accessor_if.sv
// Bundle of CPU request/response and byte-bus signals for mem_burst_accessor.
// The slave modport is the accessor's view. The master modport is the CPU and memory side.
interface mem_burst_accessor_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [CNT_W-1:0]        req_bytes;
  logic [8*WORD_BYTES-1:0] req_wdata;
  logic                    resp_valid;
  logic [8*WORD_BYTES-1:0] resp_rdata;
  logic                    resp_error;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic [7:0]              read_value;
  logic                    write;
  logic [7:0]              write_value;

  modport slave (
    input  req_valid, req_write, req_address, req_bytes, req_wdata, ready, read_value,
    output req_ready, resp_valid, resp_rdata, resp_error, address, read, write, write_value
  );

  modport master (
    output req_valid, req_write, req_address, req_bytes, req_wdata, ready, read_value,
    input  req_ready, resp_valid, resp_rdata, resp_error, address, read, write, write_value
  );
endinterface

// File: rtl/mem_burst_accessor.sv
// Serialises one 1..WORD_BYTES CPU access into little-endian byte transactions,
// with a per-byte ready timeout.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request, req_ready=1
//   ST_ACCESS | byte idx presented on the bus, waiting for ready
//   ST_RESP   | one-cycle resp_valid pulse
module mem_burst_accessor #(
  parameter int ADDR_WIDTH     = 16,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(WORD_BYTES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_burst_accessor_if.slave  bus
);
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WORD_BYTES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]              state_q;
  logic                    wflag_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [8*WORD_BYTES-1:0] wdata_q;
  logic [IDX_W-1:0]        idx_q;
  logic [TO_W-1:0]         wait_q;
  logic [8*WORD_BYTES-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic                    read_q;
  logic                    write_q;
  logic [7:0]              wvalue_q;
  logic                    resp_valid_q;
  logic                    resp_error_q;

  logic [IDX_W-1:0] idx_nxt;
  logic             last_byte;
  logic             timed_out;
  logic             count_ok;

  always_comb begin
    idx_nxt   = idx_q + IDX_W'(1);
    last_byte = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));
    timed_out = (TIMEOUT_CYCLES > 0) && (wait_q == TO_LAST);
    count_ok  = (bus.req_bytes != '0) && (bus.req_bytes <= MAX_CNT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wflag_q      <= 1'b0;
      base_q       <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      rdata_q      <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wvalue_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            wflag_q <= bus.req_write;
            base_q  <= bus.req_address;
            cnt_q   <= bus.req_bytes;
            wdata_q <= bus.req_wdata;
            idx_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            if (count_ok) begin
              state_q   <= ST_ACCESS;
              address_q <= bus.req_address;
              read_q    <= ~bus.req_write;
              write_q   <= bus.req_write;
              wvalue_q  <= bus.req_wdata[7:0];
            end else begin
              // Illegal count: answer with an error without touching the bus.
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.ready) begin
            wait_q <= '0;
            if (!wflag_q)
              rdata_q[{idx_q, 3'b000} +: 8] <= bus.read_value;
            if (last_byte) begin
              state_q      <= ST_RESP;
              read_q       <= 1'b0;
              write_q      <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b0;
            end else begin
              // Strobes stay high; only address and data advance.
              idx_q     <= idx_nxt;
              address_q <= base_q + ADDR_WIDTH'(idx_nxt);
              wvalue_q  <= wdata_q[{idx_nxt, 3'b000} +: 8];
            end
          end else if (timed_out) begin
            state_q      <= ST_RESP;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TO_W'(1);
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_error  = resp_error_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.address     = address_q;
  assign bus.read        = read_q;
  assign bus.write       = write_q;
  assign bus.write_value = wvalue_q;
endmodule

// File: tb/tb_mem_burst_accessor.sv
// Directed bench for mem_burst_accessor: bursts, address wrap, wait states,
// timeout, illegal counts and reset mid-transaction.
module tb_mem_burst_accessor;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  mem_burst_accessor_if #(.ADDR_WIDTH(16), .WORD_BYTES(4)) bus ();

  mem_burst_accessor #(
    .ADDR_WIDTH(16), .WORD_BYTES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes(input string tag, input logic rd, input logic wr);
    chk({tag, "_read"}, 32'(bus.read), 32'(rd));
    chk({tag, "_write"}, 32'(bus.write), 32'(wr));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_address = '0;
    bus.req_bytes   = '0;
    bus.req_wdata   = '0;
    bus.ready       = 1'b0;
    bus.read_value  = '0;
    repeat (2) @(negedge clock);

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_address", 32'(bus.address), 32'd0);
    chk("rst_write_value", 32'(bus.write_value), 32'd0);
    chk_strobes("rst", 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // 4-byte read at 0x0100, ready always high
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0100;
    bus.req_bytes = 3'd4; bus.ready = 1'b1; bus.read_value = 8'h11;
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rd4_address", 32'(bus.address), 32'h0100 + 32'(i));
      chk_strobes("rd4", 1'b1, 1'b0);
      chk("rd4_req_ready", 32'(bus.req_ready), 32'd0);
      bus.read_value = 8'((i + 1) * 8'h11);
      @(negedge clock);
    end
    chk("rd4_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("rd4_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rd4_resp_rdata", bus.resp_rdata, 32'h44332211);
    chk_strobes("rd4_resp", 1'b0, 1'b0);
    @(negedge clock);
    chk("rd4_pulse_end", 32'(bus.resp_valid), 32'd0);
    chk("rd4_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("rd4_rdata_hold", bus.resp_rdata, 32'h44332211);

    // 2-byte write at 0xFFFF wrapping to 0x0000
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 16'hFFFF;
    bus.req_bytes = 3'd2; bus.req_wdata = 32'h0000BEEF;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("wr2_addr0", 32'(bus.address), 32'h0000FFFF);
    chk("wr2_val0", 32'(bus.write_value), 32'hEF);
    chk_strobes("wr2_b0", 1'b0, 1'b1);
    @(negedge clock);
    chk("wr2_addr1", 32'(bus.address), 32'h00000000);
    chk("wr2_val1", 32'(bus.write_value), 32'hBE);
    chk_strobes("wr2_b1", 1'b0, 1'b1);
    @(negedge clock);
    chk("wr2_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("wr2_resp_error", 32'(bus.resp_error), 32'd0);
    chk("wr2_resp_rdata", bus.resp_rdata, 32'd0);
    chk_strobes("wr2_resp", 1'b0, 1'b0);
    @(negedge clock);

    // 1-byte read at 0x0200 with three wait cycles
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0200;
    bus.req_bytes = 3'd1; bus.ready = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wait_address", 32'(bus.address), 32'h0200);
      chk("wait_read", 32'(bus.read), 32'd1);
      chk("wait_no_resp", 32'(bus.resp_valid), 32'd0);
      if (i == 3) begin
        bus.ready = 1'b1;
        bus.read_value = 8'hA5;
      end
      @(negedge clock);
    end
    chk("wait_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("wait_resp_error", 32'(bus.resp_error), 32'd0);
    chk("wait_resp_rdata", bus.resp_rdata, 32'h000000A5);
    @(negedge clock);

    // 3-byte read at 0x0300; byte 1 never acknowledged -> timeout after 8 cycles
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0300;
    bus.req_bytes = 3'd3; bus.ready = 1'b1; bus.read_value = 8'h5A;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("to_addr0", 32'(bus.address), 32'h0300);
    @(negedge clock);
    chk("to_addr1", 32'(bus.address), 32'h0301);
    chk("to_read1", 32'(bus.read), 32'd1);
    bus.ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk("to_still_waiting", 32'(bus.resp_valid), 32'd0);
      chk("to_addr_held", 32'(bus.address), 32'h0301);
    end
    @(negedge clock);
    chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_resp_error", 32'(bus.resp_error), 32'd1);
    chk("to_resp_rdata", bus.resp_rdata, 32'h0000005A);
    chk_strobes("to_resp", 1'b0, 1'b0);
    @(negedge clock);
    chk("to_pulse_end", 32'(bus.resp_valid), 32'd0);
    bus.ready = 1'b1;

    // Illegal counts 0 and 5
    for (int k = 0; k < 2; k++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0600;
      bus.req_bytes = (k == 0) ? 3'd0 : 3'd5;
      @(negedge clock);
      bus.req_valid = 1'b0;
      chk("bad_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bad_resp_error", 32'(bus.resp_error), 32'd1);
      chk("bad_resp_rdata", bus.resp_rdata, 32'd0);
      chk_strobes("bad", 1'b0, 1'b0);
      @(negedge clock);
      chk("bad_pulse_end", 32'(bus.resp_valid), 32'd0);
      chk("bad_idle_ready", 32'(bus.req_ready), 32'd1);
    end

    // 4-byte write interrupted by reset while byte 2 is on the bus
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 16'h0400;
    bus.req_bytes = 3'd4; bus.req_wdata = 32'hDDCCBBAA;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rstmid_addr2", 32'(bus.address), 32'h0402);
    chk("rstmid_val2", 32'(bus.write_value), 32'hCC);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_strobes("rstmid", 1'b0, 1'b0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clock);
    chk("rstmid_no_resp", 32'(bus.resp_valid), 32'd0);

    // Follow-up 1-byte read completes normally
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_address = 16'h0500;
    bus.req_bytes = 3'd1; bus.read_value = 8'h77;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("after_addr", 32'(bus.address), 32'h0500);
    chk_strobes("after", 1'b1, 1'b0);
    @(negedge clock);
    chk("after_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("after_resp_error", 32'(bus.resp_error), 32'd0);
    chk("after_resp_rdata", bus.resp_rdata, 32'h00000077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_burst_accessor.md
Name: mem_burst_accessor

Overview:
- Parametrised successor to the byte-wide memory accessor between cpu and memory.
- Accepts one multi-byte (1..WORD_BYTES) read or write request from the CPU side and serialises it into little-endian single-byte transactions on the existing ready/address/read/read_value/write/write_value bus.
- Adds a per-byte wait timeout with error reporting.
- Lets the CPU issue word accesses without sequencing bytes itself.

Parameters:
- ADDR_WIDTH, 16: address width in bits; equals the architecture size.
- WORD_BYTES, 4: maximum bytes per request; must be ≥1.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for ready per byte; 0 disables the timeout.
- CNT_W, $clog2(WORD_BYTES+1): width of req_bytes (derived).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  accessor can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDR_WIDTH  base byte address.
- req_bytes  in  CNT_W  byte count; legal range 1..WORD_BYTES.
- req_wdata  in  8*WORD_BYTES  write data; byte i = bits [8i+7:8i].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8*WORD_BYTES  read data, little-endian.
- resp_error  out  1  qualifies resp_valid: timeout or illegal count.
- ready  in  1  memory has completed the current byte.
- address  out  ADDR_WIDTH  current byte address.
- read  out  1  byte read strobe.
- read_value  in  8  read byte; valid when ready=1.
- write  out  1  byte write strobe.
- write_value  out  8  byte to write.

Behaviour:

Reset:
- Synchronous, active-high; state goes to IDLE.
- req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, read=0, write=0, address=0, write_value=0.
- Reset asserted mid-transaction: strobes are 0 from the next edge. No response is issued and the transaction is discarded.

States:
- IDLE
  - req_ready=1; strobes 0.
  - req_valid=1 captures write flag, address, count and wdata. Internal byte index idx=0; rdata buffer is cleared.
  - Legal count → go to ACCESS. Count 0 or >WORD_BYTES → go to RESP with error=1 and no bus activity.
  - ready is ignored in IDLE.
- ACCESS
  - req_ready=0.
  - address = base + idx, modulo 2^ADDR_WIDTH (wraps at the top).
  - read = !write_flag, write = write_flag. write_value = wdata byte idx.
  - Strobes and address are registered and stable until the cycle ready is sampled 1.
  - ready=1 on an edge completes byte idx. On a read, read_value is stored into rdata byte idx. The wait counter clears.
    - If idx == count-1 → go to RESP.
    - Otherwise idx+1 and stay in ACCESS; the next byte's address and value are presented the following cycle. Strobes stay asserted continuously across bytes (back-to-back).
  - ready=0: the wait counter increments. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES → go to RESP with error=1. Bytes already written stay written; partial rdata is kept.
- RESP
  - Strobes 0; resp_valid=1 for exactly one cycle with resp_error and resp_rdata; then go to IDLE.
  - resp_rdata holds its value until the next request is accepted.
  - Bytes ≥ count are zero. On a write, resp_rdata is all-zero.

Latency:
- N-byte request with ready permanently high: accept edge, then N ACCESS cycles, then resp_valid on cycle N+1 after acceptance.
- Minimum issue interval is N+2 cycles.

Simultaneous events and ordering:
- req_valid during ACCESS or RESP is not accepted (req_ready=0); the CPU holds the request.
- read and write are never both 1.

Test Plan:
- Read 4 bytes @0x0100, memory returns 0x11,0x22,0x33,0x44 with ready always 1 → addresses 0x0100..0x0103 on consecutive cycles, resp_valid with resp_rdata=0x44332211, error=0, 6 cycles from accept to idle.
- Write 2 bytes @0xFFFF, wdata=0x0000BEEF → write_value 0xEF @0xFFFF, then 0xBE @0x0000 (wrap); resp_rdata=0, error=0.
- Read 1 byte with ready delayed 3 cycles → address/read held stable for 4 cycles; rdata=0x000000VV.
- TIMEOUT_CYCLES=8, ready never asserted on byte 1 of a 3-byte read → byte 0 captured; resp_error=1 exactly 8 cycles after byte 1 is presented; rdata holds byte 0 only.
- req_bytes=0 and req_bytes=5 → no strobe asserted, resp_valid with error=1 one cycle after accept.
- Reset asserted during byte 2 of a write → strobes 0 next cycle, no resp_valid, req_ready=1; a subsequent request completes normally.
